// File: rtl/w_router_pkg.sv
// rtl/w_router_pkg.sv - shared widths, target/state enums and address map for the W router
package w_router_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [2:0] {
        TGT_S0      = 3'd0,
        TGT_S1      = 3'd1,
        TGT_S2      = 3'd2,
        TGT_S4      = 3'd3,
        TGT_DEFAULT = 3'd4
    } target_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } w_state_e;

    localparam logic [ADDR_W-1:0] S0_HI = 32'h0000_1FFF;
    localparam logic [ADDR_W-1:0] S1_LO = 32'h0001_0000;
    localparam logic [ADDR_W-1:0] S1_HI = 32'h0001_FFFF;
    localparam logic [ADDR_W-1:0] S2_LO = 32'h0002_0000;
    localparam logic [ADDR_W-1:0] S2_HI = 32'h0002_FFFF;
    localparam logic [ADDR_W-1:0] S4_LO = 32'h2000_0000;
    localparam logic [ADDR_W-1:0] S4_HI = 32'h201F_FFFF;

    // S0 starts at address zero, so only its upper bound needs a compare.
    function automatic target_e decode_target(input logic [ADDR_W-1:0] addr);
        target_e t;
        if (addr <= S0_HI)
            t = TGT_S0;
        else if (addr >= S1_LO && addr <= S1_HI)
            t = TGT_S1;
        else if (addr >= S2_LO && addr <= S2_HI)
            t = TGT_S2;
        else if (addr >= S4_LO && addr <= S4_HI)
            t = TGT_S4;
        else
            t = TGT_DEFAULT;
        return t;
    endfunction

endpackage

// File: rtl/w_beat_ctr.sv
// rtl/w_beat_ctr.sv - burst length latch, beat counter and last-beat compare
import w_router_pkg::*;

module w_beat_ctr (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] len_in,
    input  logic             inc,
    output logic [LEN_W-1:0] cnt,
    output logic [LEN_W-1:0] len,
    output logic             is_last
);

    // Length is captured at AW time; the count restarts then and advances per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            len <= '0;
        end else if (load) begin
            cnt <= '0;
            len <= len_in;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign is_last = (cnt == len);

endmodule

// File: rtl/w_router.sv
// rtl/w_router.sv - routes master write-data beats to the slave selected at AW time
import w_router_pkg::*;

module w_router (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ADDR_W-1:0] AWADDR_M1,
    input  logic [LEN_W-1:0]  AWLEN_M1,
    input  logic              AWVALID_M1,
    input  logic              AWREADY_M1,
    input  logic [DATA_W-1:0] WDATA_M1,
    input  logic [STRB_W-1:0] WSTRB_M1,
    input  logic              WLAST_M1,
    input  logic              WVALID_M1,
    output logic              WREADY_M1,
    output logic [DATA_W-1:0] WDATA_S0,
    output logic [STRB_W-1:0] WSTRB_S0,
    output logic              WLAST_S0,
    output logic              WVALID_S0,
    input  logic              WREADY_S0,
    output logic [DATA_W-1:0] WDATA_S1,
    output logic [STRB_W-1:0] WSTRB_S1,
    output logic              WLAST_S1,
    output logic              WVALID_S1,
    input  logic              WREADY_S1,
    output logic [DATA_W-1:0] WDATA_S2,
    output logic [STRB_W-1:0] WSTRB_S2,
    output logic              WLAST_S2,
    output logic              WVALID_S2,
    input  logic              WREADY_S2,
    output logic [DATA_W-1:0] WDATA_S4,
    output logic [STRB_W-1:0] WSTRB_S4,
    output logic              WLAST_S4,
    output logic              WVALID_S4,
    input  logic              WREADY_S4,
    output logic [DATA_W-1:0] WDATA_DEFAULT,
    output logic [STRB_W-1:0] WSTRB_DEFAULT,
    output logic              WLAST_DEFAULT,
    output logic              WVALID_DEFAULT,
    input  logic              WREADY_DEFAULT,
    input  logic              BVALID_M1,
    input  logic              BREADY_M1,
    output logic              W_BUSY,
    output logic              W_LAST_ERR
);

    w_state_e         state;
    w_state_e         state_nxt;
    target_e          target;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             load;
    logic             is_last;
    logic             sel_ready;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len;

    assign aw_hs = AWVALID_M1 & AWREADY_M1;
    assign w_hs  = WVALID_M1 & WREADY_M1;
    assign b_hs  = BVALID_M1 & BREADY_M1;
    assign load  = (state == ST_IDLE) & aw_hs;

    assign WDATA_S0      = WDATA_M1;
    assign WDATA_S1      = WDATA_M1;
    assign WDATA_S2      = WDATA_M1;
    assign WDATA_S4      = WDATA_M1;
    assign WDATA_DEFAULT = WDATA_M1;
    assign WSTRB_S0      = WSTRB_M1;
    assign WSTRB_S1      = WSTRB_M1;
    assign WSTRB_S2      = WSTRB_M1;
    assign WSTRB_S4      = WSTRB_M1;
    assign WSTRB_DEFAULT = WSTRB_M1;

    assign W_BUSY = (state != ST_IDLE);

    w_beat_ctr u_beat_ctr (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .load    (load),
        .len_in  (AWLEN_M1),
        .inc     (w_hs),
        .cnt     (cnt),
        .len     (len),
        .is_last (is_last)
    );

    // State, latched target and the sticky WLAST mismatch flag.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= ST_IDLE;
            target     <= TGT_DEFAULT;
            W_LAST_ERR <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load)
                target <= decode_target(AWADDR_M1);
            if (w_hs && (WLAST_M1 != is_last))
                W_LAST_ERR <= 1'b1;
        end
    end

    // Next state: AW opens a burst, the counted last beat closes it, B releases the channel.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (aw_hs)            state_nxt = ST_DATA;
            ST_DATA: if (w_hs && is_last)  state_nxt = ST_RESP;
            ST_RESP: if (b_hs)             state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    // Steer valid/last to the latched target and return that slave's ready, only while in DATA.
    always_comb begin
        WVALID_S0      = 1'b0;
        WVALID_S1      = 1'b0;
        WVALID_S2      = 1'b0;
        WVALID_S4      = 1'b0;
        WVALID_DEFAULT = 1'b0;
        WLAST_S0       = 1'b0;
        WLAST_S1       = 1'b0;
        WLAST_S2       = 1'b0;
        WLAST_S4       = 1'b0;
        WLAST_DEFAULT  = 1'b0;
        sel_ready      = 1'b0;
        if (state == ST_DATA) begin
            case (target)
                TGT_S0: begin
                    WVALID_S0 = WVALID_M1;
                    WLAST_S0  = is_last;
                    sel_ready = WREADY_S0;
                end
                TGT_S1: begin
                    WVALID_S1 = WVALID_M1;
                    WLAST_S1  = is_last;
                    sel_ready = WREADY_S1;
                end
                TGT_S2: begin
                    WVALID_S2 = WVALID_M1;
                    WLAST_S2  = is_last;
                    sel_ready = WREADY_S2;
                end
                TGT_S4: begin
                    WVALID_S4 = WVALID_M1;
                    WLAST_S4  = is_last;
                    sel_ready = WREADY_S4;
                end
                default: begin
                    WVALID_DEFAULT = WVALID_M1;
                    WLAST_DEFAULT  = is_last;
                    sel_ready      = WREADY_DEFAULT;
                end
            endcase
        end
        WREADY_M1 = sel_ready;
    end

endmodule

// File: tb/tb_w_router.sv
// tb/tb_w_router.sv - directed self-checking bench for w_router
module tb_w_router;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] AWADDR_M1;
    logic [3:0]  AWLEN_M1;
    logic        AWVALID_M1, AWREADY_M1;
    logic [31:0] WDATA_M1;
    logic [3:0]  WSTRB_M1;
    logic        WLAST_M1, WVALID_M1, WREADY_M1;
    logic [31:0] WDATA_S0, WDATA_S1, WDATA_S2, WDATA_S4, WDATA_DEFAULT;
    logic [3:0]  WSTRB_S0, WSTRB_S1, WSTRB_S2, WSTRB_S4, WSTRB_DEFAULT;
    logic        WLAST_S0, WLAST_S1, WLAST_S2, WLAST_S4, WLAST_DEFAULT;
    logic        WVALID_S0, WVALID_S1, WVALID_S2, WVALID_S4, WVALID_DEFAULT;
    logic        WREADY_S0, WREADY_S1, WREADY_S2, WREADY_S4, WREADY_DEFAULT;
    logic        BVALID_M1, BREADY_M1;
    logic        W_BUSY, W_LAST_ERR;

    int vectors = 0;
    int miscompares = 0;

    logic [4:0] wv;
    logic [4:0] wl;
    assign wv = {WVALID_DEFAULT, WVALID_S4, WVALID_S2, WVALID_S1, WVALID_S0};
    assign wl = {WLAST_DEFAULT, WLAST_S4, WLAST_S2, WLAST_S1, WLAST_S0};

    localparam logic [4:0] V_S0  = 5'b00001;
    localparam logic [4:0] V_S1  = 5'b00010;
    localparam logic [4:0] V_S2  = 5'b00100;
    localparam logic [4:0] V_S4  = 5'b01000;
    localparam logic [4:0] V_DEF = 5'b10000;

    always #5 ACLK = ~ACLK;

    w_router dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1),
        .AWVALID_M1(AWVALID_M1), .AWREADY_M1(AWREADY_M1),
        .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WLAST_M1(WLAST_M1),
        .WVALID_M1(WVALID_M1), .WREADY_M1(WREADY_M1),
        .WDATA_S0(WDATA_S0), .WSTRB_S0(WSTRB_S0), .WLAST_S0(WLAST_S0),
        .WVALID_S0(WVALID_S0), .WREADY_S0(WREADY_S0),
        .WDATA_S1(WDATA_S1), .WSTRB_S1(WSTRB_S1), .WLAST_S1(WLAST_S1),
        .WVALID_S1(WVALID_S1), .WREADY_S1(WREADY_S1),
        .WDATA_S2(WDATA_S2), .WSTRB_S2(WSTRB_S2), .WLAST_S2(WLAST_S2),
        .WVALID_S2(WVALID_S2), .WREADY_S2(WREADY_S2),
        .WDATA_S4(WDATA_S4), .WSTRB_S4(WSTRB_S4), .WLAST_S4(WLAST_S4),
        .WVALID_S4(WVALID_S4), .WREADY_S4(WREADY_S4),
        .WDATA_DEFAULT(WDATA_DEFAULT), .WSTRB_DEFAULT(WSTRB_DEFAULT),
        .WLAST_DEFAULT(WLAST_DEFAULT), .WVALID_DEFAULT(WVALID_DEFAULT),
        .WREADY_DEFAULT(WREADY_DEFAULT),
        .BVALID_M1(BVALID_M1), .BREADY_M1(BREADY_M1),
        .W_BUSY(W_BUSY), .W_LAST_ERR(W_LAST_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge and let outputs settle before the next checks.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_ready(input logic [4:0] r);
        {WREADY_DEFAULT, WREADY_S4, WREADY_S2, WREADY_S1, WREADY_S0} = r;
    endtask

    task automatic aw(input logic [31:0] addr, input logic [3:0] len);
        AWADDR_M1 = addr; AWLEN_M1 = len; AWVALID_M1 = 1'b1; AWREADY_M1 = 1'b1;
        tick();
        AWVALID_M1 = 1'b0; AWREADY_M1 = 1'b0;
    endtask

    task automatic b_done();
        BVALID_M1 = 1'b1; BREADY_M1 = 1'b1;
        tick();
        BVALID_M1 = 1'b0; BREADY_M1 = 1'b0;
    endtask

    // Single-beat burst used for address decode boundaries.
    task automatic burst1(input logic [31:0] addr, input logic [4:0] exp_v, input string tag);
        aw(addr, 4'd0);
        WVALID_M1 = 1'b1; WLAST_M1 = 1'b1; #1;
        chk({tag, "_wvalid"}, 32'(wv), 32'(exp_v));
        chk({tag, "_wlast"}, 32'(wl), 32'(exp_v));
        tick();
        WVALID_M1 = 1'b0; WLAST_M1 = 1'b0;
        b_done();
    endtask

    initial begin
        ARESETn = 1'b0;
        AWADDR_M1 = '0; AWLEN_M1 = '0; AWVALID_M1 = 0; AWREADY_M1 = 0;
        WDATA_M1 = 32'hA5A5_0001; WSTRB_M1 = 4'hF; WLAST_M1 = 0; WVALID_M1 = 0;
        BVALID_M1 = 0; BREADY_M1 = 0;
        set_ready(5'b00000);
        #2;
        chk("rst_busy", 32'(W_BUSY), 32'd0);
        chk("rst_err", 32'(W_LAST_ERR), 32'd0);
        chk("rst_wready", 32'(WREADY_M1), 32'd0);
        chk("rst_wlast", 32'(wl), 32'd0);
        tick(); tick();
        ARESETn = 1'b1;
        tick();

        // WVALID in IDLE and during the AW handshake cycle is not accepted.
        set_ready(V_S1);
        WVALID_M1 = 1'b1; #1;
        chk("idle_wready", 32'(WREADY_M1), 32'd0);
        chk("idle_wvalid", 32'(wv), 32'd0);
        AWADDR_M1 = 32'h0001_0040; AWLEN_M1 = 4'd3; AWVALID_M1 = 1; AWREADY_M1 = 1; #1;
        chk("awcyc_wready", 32'(WREADY_M1), 32'd0);
        chk("awcyc_wvalid", 32'(wv), 32'd0);
        tick();
        AWVALID_M1 = 0; AWREADY_M1 = 0;

        // Four-beat burst to S1.
        for (int i = 0; i < 4; i++) begin
            WDATA_M1 = 32'h1000_0000 + i; WLAST_M1 = (i == 3); #1;
            chk("s1_wvalid", 32'(wv), 32'(V_S1));
            chk("s1_wready", 32'(WREADY_M1), 32'd1);
            chk("s1_wlast", 32'(wl), (i == 3) ? 32'(V_S1) : 32'd0);
            chk("s1_wdata", WDATA_S1, 32'h1000_0000 + i);
            chk("s1_busy", 32'(W_BUSY), 32'd1);
            tick();
        end
        WVALID_M1 = 0; WLAST_M1 = 0;
        WVALID_M1 = 1; #1;
        chk("resp_wready", 32'(WREADY_M1), 32'd0);
        chk("resp_wvalid", 32'(wv), 32'd0);
        WVALID_M1 = 0;
        BVALID_M1 = 1; BREADY_M1 = 0;
        tick();
        chk("resp_hold_busy", 32'(W_BUSY), 32'd1);
        BREADY_M1 = 1;
        tick();
        BVALID_M1 = 0; BREADY_M1 = 0;
        chk("resp_done_busy", 32'(W_BUSY), 32'd0);
        chk("s1_err", 32'(W_LAST_ERR), 32'd0);

        // Single beat to S4; busy window.
        set_ready(V_S4);
        AWADDR_M1 = 32'h2000_0000; AWLEN_M1 = 4'd0; AWVALID_M1 = 1; AWREADY_M1 = 1; #1;
        chk("s4_busy_awcyc", 32'(W_BUSY), 32'd0);
        tick();
        AWVALID_M1 = 0; AWREADY_M1 = 0;
        chk("s4_busy_data", 32'(W_BUSY), 32'd1);
        WVALID_M1 = 1; WLAST_M1 = 1; #1;
        chk("s4_wvalid", 32'(wv), 32'(V_S4));
        chk("s4_wlast", 32'(wl), 32'(V_S4));
        tick();
        WVALID_M1 = 0; WLAST_M1 = 0;
        chk("s4_busy_resp", 32'(W_BUSY), 32'd1);
        b_done();
        chk("s4_busy_idle", 32'(W_BUSY), 32'd0);

        // Unmapped address to DEFAULT with a stall; early B ignored in DATA.
        set_ready(5'b01111);
        aw(32'h8000_0000, 4'd0);
        WVALID_M1 = 1; WLAST_M1 = 1; BVALID_M1 = 1; BREADY_M1 = 1; #1;
        chk("def_wvalid", 32'(wv), 32'(V_DEF));
        chk("def_stall_wready", 32'(WREADY_M1), 32'd0);
        tick();
        BVALID_M1 = 0; BREADY_M1 = 0;
        chk("def_stall_hold", 32'(wv), 32'(V_DEF));
        set_ready(V_DEF); #1;
        chk("def_wready", 32'(WREADY_M1), 32'd1);
        tick();
        WVALID_M1 = 0; WLAST_M1 = 0;
        chk("def_resp_busy", 32'(W_BUSY), 32'd1);
        b_done();

        // Decode boundaries.
        set_ready(5'b11111);
        burst1(32'h0000_1FFC, V_S0, "s0_top");
        burst1(32'h0000_2000, V_DEF, "s0_above");
        burst1(32'h0002_0000, V_S2, "s2_base");
        burst1(32'h201F_FFFC, V_S4, "s4_top");
        burst1(32'h2020_0000, V_DEF, "s4_above");
        burst1(32'h0000_FFFC, V_DEF, "gap_s0_s1");

        // Early WLAST from master on a two-beat burst.
        aw(32'h0001_0000, 4'd1);
        WVALID_M1 = 1; WLAST_M1 = 1; #1;
        chk("err_b1_wlast", 32'(wl), 32'd0);
        tick();
        chk("err_set", 32'(W_LAST_ERR), 32'd1);
        chk("err_b2_wlast", 32'(wl), 32'(V_S1));
        tick();
        WVALID_M1 = 0; WLAST_M1 = 0;
        chk("err_resp_busy", 32'(W_BUSY), 32'd1);
        b_done();
        burst1(32'h0000_0000, V_S0, "err_next");
        chk("err_sticky", 32'(W_LAST_ERR), 32'd1);

        // Reset mid-burst at cnt 2 of len 3.
        aw(32'h0001_0000, 4'd3);
        WVALID_M1 = 1; WLAST_M1 = 0;
        tick(); tick();
        #2;
        ARESETn = 1'b0; #1;
        chk("mid_rst_busy", 32'(W_BUSY), 32'd0);
        chk("mid_rst_wready", 32'(WREADY_M1), 32'd0);
        chk("mid_rst_wvalid", 32'(wv), 32'd0);
        chk("mid_rst_err", 32'(W_LAST_ERR), 32'd0);
        WVALID_M1 = 0;
        tick();
        ARESETn = 1'b1;
        tick();
        aw(32'h0001_0000, 4'd1);
        WVALID_M1 = 1; #1;
        chk("post_rst_b1_wlast", 32'(wl), 32'd0);
        tick();
        WLAST_M1 = 1; #1;
        chk("post_rst_b2_wlast", 32'(wl), 32'(V_S1));
        tick();
        WVALID_M1 = 0; WLAST_M1 = 0;
        chk("post_rst_resp_wvalid", 32'(wv), 32'd0);
        chk("post_rst_resp_busy", 32'(W_BUSY), 32'd1);
        chk("post_rst_err", 32'(W_LAST_ERR), 32'd0);
        b_done();
        chk("post_rst_idle", 32'(W_BUSY), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
